hgcal_input_quantizer: RTL and testbench

Front-end stage for the HGCAL autoencoder: accepts a stream of signed sensor samples over a valid/ready handshake, quantises each sample to a 2-bit code with three fixed thresholds, and assembles N_IN codes into one flat input word. That word feeds the first LUT-neuron layer directly (bit-sliced per neuron). Assembly and output registers are double-buffered, so frame k+1 is collected while frame k waits for the layer to consume it.

---
 rtl/hgcal_pkg.sv | 32 +++
 rtl/hgcal_thresh_quant.sv | 17 +
 rtl/hgcal_input_quantizer.sv | 167 ++++++++++++++++
 tb/tb_hgcal_input_quantizer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_pkg.sv
// Shared types, default thresholds and the reference quantiser for the
// HGCAL autoencoder input stage.
package hgcal_pkg;

  // Width of one quantised code.
  localparam int Q_W = 2;

  typedef logic [Q_W-1:0] code_t;

  // Default signed thresholds; callers must keep TH0 < TH1 < TH2.
  localparam int TH0_DEF = -512;
  localparam int TH1_DEF = 0;
  localparam int TH2_DEF = 512;

  // Frame assembly control states.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DROP    = 2'd2
  } state_t;

  // Map a sign-extended sample onto a 2-bit code using three ascending thresholds.
  function automatic code_t quantise(input int x, input int th0, input int th1, input int th2);
    code_t c;
    if (x >= th2)      c = code_t'(3);
    else if (x >= th1) c = code_t'(2);
    else if (x >= th0) c = code_t'(1);
    else               c = code_t'(0);
    return c;
  endfunction

endpackage

// File: rtl/hgcal_thresh_quant.sv
// Pure combinational threshold quantiser; also reused on the decoder side.
module hgcal_thresh_quant
  import hgcal_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int TH0  = TH0_DEF,
  parameter int TH1  = TH1_DEF,
  parameter int TH2  = TH2_DEF
) (
  input  logic signed [IN_W-1:0] x,
  output code_t                  code
);

  // Sign-extend to int so the comparison is signed regardless of IN_W.
  assign code = quantise(int'(x), TH0, TH1, TH2);

endmodule

// File: rtl/hgcal_input_quantizer.sv
// HGCAL autoencoder front end: quantises a stream of signed samples to 2-bit
// codes and packs N_IN codes into one frame word. The assembly buffer and the
// output register form a double buffer so the next frame is collected while
// the current one waits for the first LUT-neuron layer.
module hgcal_input_quantizer
  import hgcal_pkg::*;
#(
  parameter int N_IN = 48,
  parameter int IN_W = 16,
  parameter int TH0  = TH0_DEF,
  parameter int TH1  = TH1_DEF,
  parameter int TH2  = TH2_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_IN*Q_W-1:0]    m_data,
  output logic                   frame_err,
  output logic [15:0]            drop_cnt
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int FW    = N_IN * Q_W;

  // Saturating increment for the dropped-frame counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FW-1:0]      asm_q, asm_d, asm_wr;
  logic [FW-1:0]      out_q, out_d;
  logic               m_valid_q, m_valid_d;
  logic               s_ready_q, s_ready_d;
  logic               frame_err_q, frame_err_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  code_t              code;
  logic               s_accept;
  logic               out_free;
  logic               idx_last;

  hgcal_thresh_quant #(
    .IN_W (IN_W),
    .TH0  (TH0),
    .TH1  (TH1),
    .TH2  (TH2)
  ) u_quant (
    .x    (s_data),
    .code (code)
  );

  assign s_accept = s_valid & s_ready_q;
  // The output slot can take a new frame if empty or being drained this cycle.
  assign out_free = ~m_valid_q | m_ready;
  assign idx_last = (idx_q == IDX_W'(N_IN - 1));

  // Next-state, assembly write and output-load decisions.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    out_d       = out_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    drop_cnt_d  = drop_cnt_q;

    // Assembly buffer with the incoming code placed at the current index.
    asm_wr = asm_q;
    for (int k = 0; k < N_IN; k++) begin
      if (idx_q == IDX_W'(k)) asm_wr[k*Q_W +: Q_W] = code;
    end

    // A consumed frame empties the slot unless a new frame replaces it below.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (s_accept) begin
          asm_d = asm_wr;
          if (idx_last) begin
            if (s_last) begin
              if (out_free) begin
                out_d     = asm_wr;
                m_valid_d = 1'b1;
                idx_d     = '0;
              end else begin
                // Completed frame parks in the assembly buffer until the slot frees.
                state_d = FULL;
              end
            end else begin
              // Frame overran N_IN samples: flag once, swallow the rest.
              frame_err_d = 1'b1;
              drop_cnt_d  = sat_inc16(drop_cnt_q);
              idx_d       = '0;
              state_d     = DROP;
            end
          end else if (s_last) begin
            // Frame ended early: discard the partial frame.
            frame_err_d = 1'b1;
            drop_cnt_d  = sat_inc16(drop_cnt_q);
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (m_valid_q && m_ready) begin
          out_d     = asm_q;
          m_valid_d = 1'b1;
          idx_d     = '0;
          state_d   = COLLECT;
        end
      end
      DROP: begin
        if (s_accept && s_last) state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase

    // s_ready is a registered decode so m_ready never reaches it combinationally.
    s_ready_d = (state_d != FULL);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      out_q       <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b1;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= s_ready_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Assembly buffer contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = out_q;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Bench for hgcal_input_quantizer with N_IN = 4: directed scenarios plus a
// randomized streaming run against a behavioural frame model.
module tb_hgcal_input_quantizer;

  localparam int N_IN = 4;
  localparam int IN_W = 16;
  localparam int FW   = N_IN * 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   s_valid;
  logic                   s_ready;
  logic signed [IN_W-1:0] s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [FW-1:0]          m_data;
  logic                   frame_err;
  logic [15:0]            drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hgcal_input_quantizer #(
    .N_IN (N_IN),
    .IN_W (IN_W),
    .TH0  (-512),
    .TH1  (0),
    .TH2  (512)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference: thresholds -512 / 0 / 512 applied to the sample value.
  function automatic int model_code(input int x);
    if (x >= 512) return 3;
    if (x >= 0)   return 2;
    if (x >= -512) return 1;
    return 0;
  endfunction

  // Frame word = sum of code_k * 4^k (code k in bits 2k+1:2k).
  function automatic logic [FW-1:0] model_frame(input int xs[N_IN]);
    int w = 0;
    int scale = 1;
    for (int k = 0; k < N_IN; k++) begin
      w = w + model_code(xs[k]) * scale;
      scale = scale * 4;
    end
    return FW'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // Present one sample and return 1 ns after the edge that accepts it.
  task automatic send(input int x, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = IN_W'(x);
    s_last  = last;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      n_checks++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int xs[N_IN]);
    for (int k = 0; k < N_IN; k++) send(xs[k], k == N_IN - 1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_valid, m_data, frame_err, drop_cnt, s_ready} !== {1'b0, 8'h00, 1'b0, 16'h0000, 1'b1})
      $display("FAIL reset_state: m_valid=%b m_data=%h err=%b drop=%0d s_ready=%b, required 0 00 0 0 1",
               m_valid, m_data, frame_err, drop_cnt, s_ready);
    else n_pass++;
  endtask

  task automatic test_quant_edges();
    int fa[N_IN] = '{-513, -512, -1, 0};
    int fb[N_IN] = '{511, 512, -600, 600};
    int fc[N_IN] = '{-600, -100, 100, 600};
    do_reset();
    m_ready = 1'b1;
    send_frame(fa);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'h94))
      $display("FAIL edges_a: m_valid=%b m_data=%h, required 1 94", m_valid, m_data);
    else n_pass++;
    send(fb[0], 1'b0);
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL edges_drain: m_valid=%b, required 0", m_valid);
    else n_pass++;
    for (int k = 1; k < N_IN; k++) send(fb[k], k == N_IN - 1);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'hCE && s_ready === 1'b1))
      $display("FAIL edges_b: m_valid=%b m_data=%h s_ready=%b, required 1 ce 1", m_valid, m_data, s_ready);
    else n_pass++;
    send_frame(fc);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'hE4 && s_ready === 1'b1))
      $display("FAIL edges_c: m_valid=%b m_data=%h s_ready=%b, required 1 e4 1", m_valid, m_data, s_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f1[N_IN] = '{600, 600, -600, -600};
    int f2[N_IN] = '{-1, 0, -513, 512};
    do_reset();
    m_ready = 1'b0;
    send_frame(f1);
    send_frame(f2);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'h0F && s_ready === 1'b0))
      $display("FAIL bp_hold: m_valid=%b m_data=%h s_ready=%b, required 1 0f 0", m_valid, m_data, s_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (!(m_data === 8'h0F && s_ready === 1'b0))
      $display("FAIL bp_stall: m_data=%h s_ready=%b, required 0f 0", m_data, s_ready);
    else n_pass++;
    m_ready = 1'b1;
    tick();
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'hC9 && s_ready === 1'b1))
      $display("FAIL bp_release: m_valid=%b m_data=%h s_ready=%b, required 1 c9 1", m_valid, m_data, s_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL bp_empty: m_valid=%b, required 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_short_frame();
    int g[N_IN] = '{0, 0, 0, 0};
    do_reset();
    m_ready = 1'b1;
    send(700, 1'b0);
    send(-700, 1'b1);
    n_checks++;
    if (!(frame_err === 1'b1 && drop_cnt === 16'd1 && m_valid === 1'b0))
      $display("FAIL short_err: err=%b drop=%0d m_valid=%b, required 1 1 0", frame_err, drop_cnt, m_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL short_pulse: err=%b, required 0", frame_err);
    else n_pass++;
    send_frame(g);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'hAA && drop_cnt === 16'd1))
      $display("FAIL short_next: m_valid=%b m_data=%h drop=%0d, required 1 aa 1", m_valid, m_data, drop_cnt);
    else n_pass++;
  endtask

  task automatic test_long_frame();
    int g[N_IN] = '{-1000, -100, 100, 1000};
    logic bad = 1'b0;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(1000, 1'b0);
    n_checks++;
    if (!(frame_err === 1'b1 && drop_cnt === 16'd1))
      $display("FAIL long_err: err=%b drop=%0d, required 1 1", frame_err, drop_cnt);
    else n_pass++;
    send(1000, 1'b0);
    if (frame_err !== 1'b0 || m_valid !== 1'b0) bad = 1'b1;
    send(1000, 1'b1);
    if (frame_err !== 1'b0 || m_valid !== 1'b0) bad = 1'b1;
    n_checks++;
    if (bad || drop_cnt !== 16'd1)
      $display("FAIL long_discard: extra err/output seen=%b drop=%0d, required 0 1", bad, drop_cnt);
    else n_pass++;
    send_frame(g);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'hE4))
      $display("FAIL long_next: m_valid=%b m_data=%h, required 1 e4", m_valid, m_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int f[N_IN] = '{600, 600, 600, 600};
    int g[N_IN] = '{-600, -100, 100, 600};
    do_reset();
    m_ready = 1'b0;
    send_frame(f);
    send(-600, 1'b0);
    send(-600, 1'b0);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({m_valid, m_data, frame_err, drop_cnt, s_ready} !== {1'b0, 8'h00, 1'b0, 16'h0000, 1'b1})
      $display("FAIL mid_reset: m_valid=%b m_data=%h err=%b drop=%0d s_ready=%b, required 0 00 0 0 1",
               m_valid, m_data, frame_err, drop_cnt, s_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    send_frame(g);
    n_checks++;
    if (!(m_valid === 1'b1 && m_data === 8'hE4))
      $display("FAIL mid_reset_next: m_valid=%b m_data=%h, required 1 e4", m_valid, m_data);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [FW-1:0] exp_q[$];
    int  got = 0;
    int  cyc = 0;
    logic err_seen = 1'b0;
    do_reset();
    fork
      begin : producer
        for (int f = 0; f < 100; f++) begin
          int xs[N_IN];
          for (int k = 0; k < N_IN; k++) begin
            if ($urandom_range(0, 3) == 0) xs[k] = int'($signed(16'($urandom)));
            else xs[k] = int'($urandom_range(0, 2047)) - 1024;
          end
          exp_q.push_back(model_frame(xs));
          for (int k = 0; k < N_IN; k++) begin
            while ($urandom_range(0, 3) == 0) tick();
            send(xs[k], k == N_IN - 1);
          end
        end
      end
      begin : consumer
        while (got < 100 && cyc < 20000) begin
          m_ready = 1'($urandom_range(0, 1));
          if (frame_err) err_seen = 1'b1;
          if (m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0)
              $display("FAIL stream_extra: unexpected frame %h, required none", m_data);
            else if (m_data !== exp_q[0])
              $display("FAIL stream_frame%0d: m_data=%h, required %h", got, m_data, exp_q[0]);
            else n_pass++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
          end
          tick();
          cyc++;
        end
      end
    join
    m_ready = 1'b1;
    n_checks++;
    if (got != 100) $display("FAIL stream_count: frames=%0d, required 100", got);
    else n_pass++;
    n_checks++;
    if (err_seen || drop_cnt !== 16'd0)
      $display("FAIL stream_errors: err_seen=%b drop=%0d, required 0 0", err_seen, drop_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_quant_edges();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
